// File: rtl/vx_lsu_csr_pkg.sv
`default_nettype none
// ============================================================================
// vx_lsu_csr_pkg : shared constants and lane-data type for the LSU CSR responder
// Revision: 1.0
// ============================================================================
package vx_lsu_csr_pkg;

  localparam int NUM_LSU_LANES     = 4;
  localparam int LSU_CSR_ADDR_BITS = 12;
  localparam int LSU_CSR_COUNT     = 8;
  localparam int LSU_CSR_IDX_BITS  = $clog2(LSU_CSR_COUNT);
  localparam int LSU_CSR_WR_CNT_W  = 16;

  localparam logic [LSU_CSR_ADDR_BITS-1:0] LSU_CSR_BASE = 12'hBC0;

  typedef logic [NUM_LSU_LANES-1:0][31:0] lsu_csr_data_t;

  // Window hit: every address bit above the index field must match the base.
  function automatic logic csr_in_window(
    input logic [LSU_CSR_ADDR_BITS-1:0] addr,
    input logic [LSU_CSR_ADDR_BITS-1:0] base,
    input int unsigned                  idx_bits
  );
    return (addr >> idx_bits) == (base >> idx_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_lsu_csr_bank.sv
`default_nettype none
// ============================================================================
// vx_lsu_csr_bank : NUM_REGS x NUM_LANES x 32 register array, one write port,
//                   one registered read port with write-first bypass
// Revision: 1.0
// ============================================================================
module vx_lsu_csr_bank
  import vx_lsu_csr_pkg::*;
#(
  parameter int          NUM_LANES   = NUM_LSU_LANES,
  parameter int          NUM_REGS    = LSU_CSR_COUNT,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  localparam int         IDX_W       = $clog2(NUM_REGS),
  localparam int         DATA_W      = NUM_LANES * 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_hit_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_q[r] <= {NUM_LANES{RESET_VALUE}};
      end else if (wr_en_i && (wr_idx_i == IDX_W'(r))) begin
        mem_q[r] <= wr_data_i;
      end
    end
  end

  // A same-cycle write to the read index wins, so the response carries new data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (!rd_hit_i) begin
        rd_data_d = '0;
      end else if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = mem_q[rd_idx_i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/vx_lsu_csr_responder.sv
`default_nettype none
// ============================================================================
// vx_lsu_csr_responder : LSU-to-CSR request responder; window decode, error
//                        pulses and saturating write counter around the bank
// Revision: 1.0
// ============================================================================
module vx_lsu_csr_responder
  import vx_lsu_csr_pkg::*;
#(
  parameter int                            NUM_LANES   = NUM_LSU_LANES,
  parameter int                            NUM_REGS    = LSU_CSR_COUNT,
  parameter logic [LSU_CSR_ADDR_BITS-1:0]  BASE_ADDR   = LSU_CSR_BASE,
  parameter logic [31:0]                   RESET_VALUE = 32'h0,
  localparam int                           ADDR_W      = LSU_CSR_ADDR_BITS,
  localparam int                           IDX_W       = $clog2(NUM_REGS),
  localparam int                           DATA_W      = NUM_LANES * 32,
  localparam int                           CNT_W       = LSU_CSR_WR_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              read_err,
  output logic              write_err,
  output logic [CNT_W-1:0]  wr_count
);

  logic             wr_hit;
  logic             rd_hit;
  logic             wr_accept;
  logic             read_valid_q, read_valid_d;
  logic             read_err_q,   read_err_d;
  logic             write_err_q,  write_err_d;
  logic [CNT_W-1:0] wr_count_q,   wr_count_d;

  // Enables gate the decode so an undriven address never reaches state.
  assign wr_hit    = write_enable && csr_in_window(write_addr, BASE_ADDR, IDX_W);
  assign rd_hit    = read_enable  && csr_in_window(read_addr,  BASE_ADDR, IDX_W);
  assign wr_accept = wr_hit;

  always_comb begin
    read_valid_d = read_enable;
    read_err_d   = read_enable  && !rd_hit;
    write_err_d  = write_enable && !wr_hit;
    wr_count_d   = wr_count_q;
    if (wr_accept && (wr_count_q != {CNT_W{1'b1}})) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid_q <= 1'b0;
      read_err_q   <= 1'b0;
      write_err_q  <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      read_valid_q <= read_valid_d;
      read_err_q   <= read_err_d;
      write_err_q  <= write_err_d;
      wr_count_q   <= wr_count_d;
    end
  end

  vx_lsu_csr_bank #(
    .NUM_LANES   (NUM_LANES),
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_accept),
    .wr_idx_i  (write_addr[IDX_W-1:0]),
    .wr_data_i (write_data),
    .rd_en_i   (read_enable),
    .rd_hit_i  (rd_hit),
    .rd_idx_i  (read_addr[IDX_W-1:0]),
    .rd_data_o (read_data)
  );

  assign read_valid = read_valid_q;
  assign read_err   = read_err_q;
  assign write_err  = write_err_q;
  assign wr_count   = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_lsu_csr_responder.sv
`default_nettype none
// ============================================================================
// tb_vx_lsu_csr_responder : directed self-checking bench for the CSR responder
// Revision: 1.0
// ============================================================================
module tb_vx_lsu_csr_responder;

  logic         clk;
  logic         reset;
  logic         write_enable;
  logic [11:0]  write_addr;
  logic [127:0] write_data;
  logic         read_enable;
  logic [11:0]  read_addr;
  logic [127:0] read_data;
  logic         read_valid;
  logic         read_err;
  logic         write_err;
  logic [15:0]  wr_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] P1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] P2 = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
  localparam logic [127:0] P7 = {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000};
  localparam logic [127:0] PS = {4{32'hCAFE0001}};

  logic [127:0] exp_regs [8];

  vx_lsu_csr_responder u_dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_err     (read_err),
    .write_err    (write_err),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b0;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_enable  = 1'b0;
    read_addr    = '0;
    repeat (2) tick();
    chk("rst_read_valid", 128'(read_valid), 128'd0);
    chk("rst_read_data",  read_data,        128'd0);
    chk("rst_wr_count",   128'(wr_count),   128'd0);
    chk("rst_errs",       128'({read_err, write_err}), 128'd0);
    reset = 1'b1;
    tick();

    // Read from a reset register
    read_enable = 1'b1; read_addr = 12'hBC3;
    tick();
    read_enable = 1'b0;
    chk("t1_valid", 128'(read_valid), 128'd1);
    chk("t1_err",   128'(read_err),   128'd0);
    chk("t1_data",  read_data,        128'd0);
    chk("t1_count", 128'(wr_count),   128'd0);

    // Write then read back
    write_enable = 1'b1; write_addr = 12'hBC2; write_data = P1;
    tick();
    write_enable = 1'b0;
    chk("t2_count",   128'(wr_count),  128'd1);
    chk("t2_wr_err",  128'(write_err), 128'd0);
    read_enable = 1'b1; read_addr = 12'hBC2;
    tick();
    read_enable = 1'b0;
    chk("t2_valid", 128'(read_valid), 128'd1);
    chk("t2_err",   128'(read_err),   128'd0);
    chk("t2_data",  read_data,        P1);

    // Same-cycle write and read of one index: write-first
    write_enable = 1'b1; write_addr = 12'hBC5; write_data = P2;
    read_enable  = 1'b1; read_addr  = 12'hBC5;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    chk("t3_valid", 128'(read_valid), 128'd1);
    chk("t3_data",  read_data,        P2);
    chk("t3_count", 128'(wr_count),   128'd2);
    tick();
    chk("t3_idle_valid", 128'(read_valid), 128'd0);
    chk("t3_hold_data",  read_data,        P2);

    // Both accesses miss the window
    write_enable = 1'b1; write_addr = 12'h300; write_data = {4{32'hDEADBEEF}};
    read_enable  = 1'b1; read_addr  = 12'h7FF;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    chk("t4_wr_err",  128'(write_err),  128'd1);
    chk("t4_valid",   128'(read_valid), 128'd1);
    chk("t4_rd_err",  128'(read_err),   128'd1);
    chk("t4_data",    read_data,        128'd0);
    chk("t4_count",   128'(wr_count),   128'd2);
    tick();
    chk("t4_wr_err_pulse", 128'(write_err), 128'd0);
    chk("t4_rd_err_clear", 128'(read_err),  128'd0);

    // Undriven addresses and data with enables low
    write_addr = 'x; write_data = 'x; read_addr = 'x;
    tick();
    chk("tx_valid",  128'(read_valid), 128'd0);
    chk("tx_wr_err", 128'(write_err),  128'd0);
    chk("tx_count",  128'(wr_count),   128'd2);
    chk("tx_data",   read_data,        128'd0);
    write_addr = '0; write_data = '0; read_addr = '0;

    // Fill the top register, then sweep the window back-to-back
    write_enable = 1'b1; write_addr = 12'hBC7; write_data = P7;
    tick();
    write_enable = 1'b0;
    chk("t5_count", 128'(wr_count), 128'd3);
    exp_regs[0] = '0; exp_regs[1] = '0; exp_regs[2] = P1; exp_regs[3] = '0;
    exp_regs[4] = '0; exp_regs[5] = P2; exp_regs[6] = '0; exp_regs[7] = P7;
    read_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_addr = 12'hBC0 + 12'(i);
      tick();
      chk($sformatf("t5_valid_%0d", i), 128'(read_valid), 128'd1);
      chk($sformatf("t5_data_%0d", i),  read_data,        exp_regs[i]);
    end
    read_enable = 1'b0;

    // Saturating write counter: starts at 3
    write_enable = 1'b1; write_addr = 12'hBC1; write_data = PS;
    repeat (65531) tick();
    chk("t6_count_fffe", 128'(wr_count), 128'h0FFFE);
    repeat (9) tick();
    write_enable = 1'b0;
    chk("t6_count_sat", 128'(wr_count), 128'h0FFFF);

    // Reset in the middle of a pending response
    read_enable = 1'b1; read_addr = 12'hBC1;
    tick();
    read_enable = 1'b0;
    chk("t6_pre_valid", 128'(read_valid), 128'd1);
    chk("t6_pre_data",  read_data,        PS);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(read_valid), 128'd0);
    chk("t6_rst_count", 128'(wr_count),   128'd0);
    tick();
    reset = 1'b1;
    tick();
    read_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_addr = 12'hBC0 + 12'(i);
      tick();
      chk($sformatf("t6_post_%0d", i), read_data, 128'd0);
    end
    read_enable = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
